pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, giving the maximum data-memory wait cycles before error (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports id_rs1 and id_rs2, input, 5 bits each: source registers of the instruction in the IF/ID register.
REQ-005 The block SHALL have port ex_memread, input, 1 bit, and port ex_rd, input, 5 bits: MemRead and rd of the ID/EX register.
REQ-006 The block SHALL have port ex_redirect, input, 1 bit: taken branch or jal/jalr resolved in EX.
REQ-007 The block SHALL have port mem_req, input, 1 bit (EX/MEM MemRead|MemWrite), and port dmem_ready, input, 1 bit (data-memory completion).
REQ-008 The block SHALL have outputs pc_en, ifid_en, idex_en, exmem_en and memwb_en, 1 bit each: register load enables.
REQ-009 The block SHALL have outputs ifid_flush, idex_flush and memwb_flush, 1 bit each: synchronous bubble inserts (control fields zeroed).
REQ-010 The block SHALL have outputs dmem_valid (1 bit, memory request strobe), stall_cycles (16 bits, performance counter) and timeout_err (1 bit, sticky error).

Function
REQ-011 The block SHALL implement FSM states RUN, MEM_WAIT and ERROR; enable, flush and dmem_valid outputs SHALL be combinational from state and inputs.
REQ-012 In RUN with no hazard, all enables SHALL be 1 and all flushes 0.
REQ-013 A load-use hazard SHALL be ex_memread=1 and ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2); in RUN it SHALL force pc_en=0, ifid_en=0, idex_flush=1 for that cycle only, with the state remaining RUN.
REQ-014 ex_redirect=1 in RUN SHALL force ifid_flush=1 and idex_flush=1 with pc_en=1 (target loaded); redirect SHALL take priority over load-use.
REQ-015 mem_req=1 and dmem_ready=0 in RUN SHALL force pc_en=ifid_en=idex_en=exmem_en=0 and memwb_flush=1, suppress redirect and load-use actions, and transition to MEM_WAIT.
REQ-016 In MEM_WAIT, outputs SHALL match REQ-015; dmem_ready=1 SHALL release all enables that cycle (RUN behaviour, including redirect/load-use evaluation) and return to RUN.
REQ-017 mem_req=1 with dmem_ready=1 in RUN SHALL cause no stall.
REQ-018 dmem_valid SHALL equal mem_req in RUN and MEM_WAIT, and 0 in ERROR.
REQ-019 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle; if it reaches MEM_TIMEOUT-1 with dmem_ready=0, the next state SHALL be ERROR.
REQ-020 ERROR SHALL be terminal until reset: all enables 0, all flushes 0, timeout_err=1.
REQ-021 stall_cycles SHALL increment on every clock edge where pc_en=0 and the state is not ERROR, and SHALL saturate at 16'hFFFF (no wrap).
REQ-022 A redirect with ex_rd==0 load-use pattern SHALL produce no stall; x0 is never a hazard.

Reset
REQ-023 reset=0 SHALL immediately force state RUN, wait counter 0, stall_cycles 0 and timeout_err 0, regardless of clk.
REQ-024 Reset asserted mid-MEM_WAIT or in ERROR SHALL return the block to RUN with all enables 1 once reset=1, given no hazard inputs.
REQ-025 Outputs during reset SHALL be the RUN no-hazard values (enables 1, flushes 0, dmem_valid=mem_req).

Verification
REQ-026 Load-use: ex_memread=1, ex_rd=5, id_rs2=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle; stall_cycles=1.
REQ-027 Redirect + load-use together: ex_redirect=1, ex_memread=1, ex_rd=3, id_rs1=3 -> ifid_flush=1, idex_flush=1, pc_en=1; stall_cycles unchanged.
REQ-028 Memory wait: mem_req=1, dmem_ready=0 for 3 cycles then 1 -> enables 0 and memwb_flush=1 for 3 cycles, release on cycle 4; stall_cycles=3.
REQ-029 Timeout: MEM_TIMEOUT=4, mem_req=1, dmem_ready held 0 -> ERROR after the 4th MEM_WAIT cycle; timeout_err=1 sticky and dmem_valid=0 until reset.
REQ-030 Saturation/reset: preload via 65540 forced load-use cycles -> stall_cycles=16'hFFFF held; asynchronous reset pulse mid-MEM_WAIT -> all counters 0, state RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard sources in, stage enables/flushes out.
// Purely combinational wiring, no storage.
// No handshake of its own; enables are the backpressure.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        dmem_ready;

    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        memwb_flush;
    logic        dmem_valid;
    logic [15:0] stall_cycles;
    logic        timeout_err;

    // Pipeline datapath side: supplies hazard sources, consumes control.
    modport master (
        output id_rs1, id_rs2, ex_memread, ex_rd, ex_redirect, mem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, memwb_flush, dmem_valid, stall_cycles, timeout_err
    );

    // Hazard controller side.
    modport slave (
        input  id_rs1, id_rs2, ex_memread, ex_rd, ex_redirect, mem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, memwb_flush, dmem_valid, stall_cycles, timeout_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard control: load-use stall, redirect flush, dmem wait with timeout.
// Enables/flushes are combinational (same cycle); counters and state update on the clock edge.
// Backpressure: a pending data-memory access freezes IF..EX/MEM and bubbles MEM/WB until dmem_ready.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    localparam logic [7:0]  WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [7:0]  wait_cnt_q;
    logic [15:0] stall_cnt_q;

    logic        load_use;
    logic        mem_stall;
    logic        wait_expired;

    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        memwb_flush;
    logic        dmem_valid;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    always_comb begin
        load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                   ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
    end

    // Once waiting, only dmem_ready ends the stall; mem_req is already latched in EX/MEM.
    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            ST_RUN:      mem_stall = hz.mem_req && !hz.dmem_ready;
            ST_MEM_WAIT: mem_stall = !hz.dmem_ready;
            default:     mem_stall = 1'b0;
        endcase
        wait_expired = (state_q == ST_MEM_WAIT) && !hz.dmem_ready &&
                       (wait_cnt_q == WAIT_LAST);
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        dmem_valid  = hz.mem_req;
        // While reset is held the pipeline sees plain RUN behaviour.
        if (reset) begin
            if (state_q == ST_ERROR) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_en    = 1'b0;
                exmem_en   = 1'b0;
                memwb_en   = 1'b0;
                dmem_valid = 1'b0;
            end else if (mem_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end else if (hz.ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ready)      state_d = ST_RUN;
                else if (wait_expired)  state_d = ST_ERROR;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_RUN && state_d == ST_MEM_WAIT)
                wait_cnt_q <= 8'd0;
            else if (state_q == ST_MEM_WAIT)
                wait_cnt_q <= wait_cnt_q + 8'd1;
            if (!pc_en && state_q != ST_ERROR && stall_cnt_q != STALL_MAX)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.idex_en      = idex_en;
    assign hz.exmem_en     = exmem_en;
    assign hz.memwb_en     = memwb_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_flush   = idex_flush;
    assign hz.memwb_flush  = memwb_flush;
    assign hz.dmem_valid   = dmem_valid;
    assign hz.stall_cycles = stall_cnt_q;
    assign hz.timeout_err  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus random bench for pipe_hazard_ctrl against a cycle-level behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_pipe_hazard_ctrl;

    localparam int T = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: sticky error flag, length of the current unbroken memory stall, stall total.
    bit m_err;
    int m_waited;
    int m_stalls;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit mem_blocked();
        if (m_waited > 0) return !bus.dmem_ready;
        return bus.mem_req && !bus.dmem_ready;
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl, dmem_valid, timeout_err}
    function automatic logic [9:0] expect_outs();
        logic [4:0] en;
        logic [2:0] fl;
        logic       dv;
        logic       te;
        bit         lu;
        en = 5'b11111;
        fl = 3'b000;
        dv = bus.mem_req;
        te = 1'b0;
        lu = bus.ex_memread && bus.ex_rd != 0 &&
             (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
        if (reset) begin
            if (m_err) begin
                en = 5'b00000; dv = 1'b0; te = 1'b1;
            end else if (mem_blocked()) begin
                en = 5'b00001; fl = 3'b001;
            end else if (bus.ex_redirect) begin
                fl = 3'b110;
            end else if (lu) begin
                en = 5'b00111; fl = 3'b010;
            end
        end
        return {en, fl, dv, te};
    endfunction

    function automatic logic [9:0] observe_outs();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.memwb_flush, bus.dmem_valid, bus.timeout_err};
    endfunction

    task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic redir, input logic mreq, input logic rdy);
        reset           = rst;
        bus.ex_memread  = mr;
        bus.ex_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.ex_redirect = redir;
        bus.mem_req     = mreq;
        bus.dmem_ready  = rdy;
        if (!rst) begin
            m_err = 1'b0; m_waited = 0; m_stalls = 0;
        end
    endtask

    // One clock cycle: check combinational outputs, clock, advance model, check counter.
    task automatic step(input string tag, input logic rst, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic redir, input logic mreq, input logic rdy);
        logic [9:0] exp;
        bit         blocked;
        drive(rst, mr, rd, rs1, rs2, redir, mreq, rdy);
        #2;
        exp = expect_outs();
        blocked = mem_blocked();
        chk({tag, ":outs"}, {6'b0, observe_outs()}, {6'b0, exp});
        @(posedge clk);
        #1;
        if (rst && !m_err) begin
            if (!exp[9] && m_stalls < 65535) m_stalls++;
            if (blocked) begin
                m_waited++;
                if (m_waited == T + 1) m_err = 1'b1;
            end else begin
                m_waited = 0;
            end
        end
        chk({tag, ":stall"}, bus.stall_cycles, 16'(m_stalls));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // Reset state, and outputs under reset even with hazard inputs present.
        step("rst_idle", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("rst_haz",  1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        chk("rst_terr", {15'b0, bus.timeout_err}, 16'd0);
        idle("run0");

        // Single-cycle load-use via rs2.
        step("lu", 1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b1);
        idle("lu_after");
        chk("lu_count", bus.stall_cycles, 16'd1);

        // Redirect wins over a simultaneous load-use.
        step("redir_lu", 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("redir_count", bus.stall_cycles, 16'd1);

        // x0 never a hazard; ready memory never stalls.
        step("x0", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("mem_rdy", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("x0_count", bus.stall_cycles, 16'd1);

        // Three unready cycles with a load-use hidden underneath, then release with a redirect.
        step("mw1", 1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
        step("mw2", 1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0);
        step("mw3", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("mw_rel", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        chk("mw_count", bus.stall_cycles, 16'd4);
        idle("mw_after");

        // Timeout: one entry cycle plus T wait cycles, then sticky ERROR.
        for (int i = 0; i < T + 1; i++)
            step("to_wait", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("to_terr", {15'b0, bus.timeout_err}, 16'd1);
        chk("to_count", bus.stall_cycles, 16'd9);
        step("err_rdy", 1'b1, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1);
        step("err_redir", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("err_dv", {15'b0, bus.dmem_valid}, 16'd0);
        chk("err_count", bus.stall_cycles, 16'd9);

        // Reset out of ERROR.
        step("err_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle("err_run");
        chk("err_run_pc", {15'b0, bus.pc_en}, 16'd1);

        // Asynchronous reset in the middle of a memory wait.
        step("mr_w1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("mr_w2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #3;
        reset = 1'b0;
        m_err = 1'b0; m_waited = 0; m_stalls = 0;
        #1;
        chk("mr_async_cnt", bus.stall_cycles, 16'd0);
        chk("mr_async_pc", {15'b0, bus.pc_en}, 16'd1);
        @(posedge clk);
        #1;
        idle("mr_run");
        chk("mr_run_en", {11'b0, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en},
            16'h001F);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step("rnd",
                 1'($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 6) == 0),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 9) < 6));
        end

        // Saturation: hold a load-use for 65540 edges.
        step("sat_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (65540) @(posedge clk);
        #1;
        m_stalls = 65535;
        chk("sat_value", bus.stall_cycles, 16'hFFFF);
        step("sat_hold", 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
        step("sat_mw", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("sat_mw_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("sat_rst_cnt", bus.stall_cycles, 16'd0);
        idle("sat_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
